// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, MIPS opcode/funct constants
// and the decoded-instruction bundle passed from decode to the ALU.
package alu_pkg;

    // 5-bit ALU operation codes
    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00110;
    localparam logic [4:0] ALU_SLTU = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_SLL  = 5'b01001;
    localparam logic [4:0] ALU_SRA  = 5'b01010;
    localparam logic [4:0] ALU_SRL  = 5'b01011;
    localparam logic [4:0] ALU_NOR  = 5'b01100;
    localparam logic [4:0] ALU_XOR  = 5'b01101;
    localparam logic [4:0] ALU_SLLV = 5'b01110;
    localparam logic [4:0] ALU_SRAV = 5'b01111;
    localparam logic [4:0] ALU_SRLV = 5'b10000;
    localparam logic [4:0] ALU_BEQ  = 5'b11000;
    localparam logic [4:0] ALU_BGTZ = 5'b11001;
    localparam logic [4:0] ALU_BLEZ = 5'b11010;
    localparam logic [4:0] ALU_BGEZ = 5'b11011;
    localparam logic [4:0] ALU_BLTZ = 5'b11111;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // REGIMM rt selectors
    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    // Decoded instruction bundle
    typedef struct packed {
        logic [4:0]  alu_control;
        logic [4:0]  as;
        logic [31:0] imm_ext;
        logic        use_imm;
        logic [4:0]  dest;
        logic        reg_write;
        logic        is_branch;
        logic        br_on_zero;
        logic        illegal;
    } decoded_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/alu_decode_table.sv
// Purely combinational MIPS decode: instruction word -> decoded bundle.
// Unsupported encodings collapse to an all-zero bundle with illegal set.
module alu_decode_table
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        legal;
    logic        unused_rs;

    assign opcode    = instr[31:26];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign shamt     = instr[10:6];
    assign funct     = instr[5:0];
    assign imm       = instr[15:0];
    // rs only feeds the register file, never the decoded bundle
    assign unused_rs = ^instr[25:21];

    // Decode one instruction; fields not meaningful for a class stay zero
    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                dec.dest      = rd;
                dec.reg_write = 1'b1;
                dec.as        = shamt;
                case (funct)
                    FN_SLL:           dec.alu_control = ALU_SLL;
                    FN_SRL:           dec.alu_control = ALU_SRL;
                    FN_SRA:           dec.alu_control = ALU_SRA;
                    FN_SLLV:          dec.alu_control = ALU_SLLV;
                    FN_SRLV:          dec.alu_control = ALU_SRLV;
                    FN_SRAV:          dec.alu_control = ALU_SRAV;
                    FN_ADD, FN_ADDU:  dec.alu_control = ALU_ADD;
                    FN_SUB, FN_SUBU:  dec.alu_control = ALU_SUB;
                    FN_AND:           dec.alu_control = ALU_AND;
                    FN_OR:            dec.alu_control = ALU_OR;
                    FN_XOR:           dec.alu_control = ALU_XOR;
                    FN_NOR:           dec.alu_control = ALU_NOR;
                    FN_SLT:           dec.alu_control = ALU_SLT;
                    FN_SLTU:          dec.alu_control = ALU_SLTU;
                    default:          legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
                dec.use_imm   = 1'b1;
                dec.dest      = rt;
                dec.reg_write = 1'b1;
                dec.imm_ext   = sext16(imm);
                case (opcode)
                    OP_SLTI:  dec.alu_control = ALU_SLT;
                    OP_SLTIU: dec.alu_control = ALU_SLTU;
                    default:  dec.alu_control = ALU_ADD;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.use_imm   = 1'b1;
                dec.dest      = rt;
                dec.reg_write = 1'b1;
                dec.imm_ext   = zext16(imm);
                case (opcode)
                    OP_ANDI: dec.alu_control = ALU_AND;
                    OP_ORI:  dec.alu_control = ALU_OR;
                    OP_XORI: dec.alu_control = ALU_XOR;
                    default: begin
                        dec.alu_control = ALU_SLL;
                        dec.as          = 5'd16;
                    end
                endcase
            end
            OP_SW: begin
                dec.use_imm     = 1'b1;
                dec.imm_ext     = sext16(imm);
                dec.alu_control = ALU_ADD;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                dec.is_branch = 1'b1;
                dec.imm_ext   = sext16(imm);
                case (opcode)
                    OP_BEQ:  dec.alu_control = ALU_BEQ;
                    OP_BNE:  dec.alu_control = ALU_SUB;
                    OP_BLEZ: begin
                        dec.alu_control = ALU_BLEZ;
                        dec.br_on_zero  = 1'b1;
                    end
                    default: begin
                        dec.alu_control = ALU_BGTZ;
                        dec.br_on_zero  = 1'b1;
                    end
                endcase
            end
            OP_REGIMM: begin
                dec.is_branch  = 1'b1;
                dec.br_on_zero = 1'b1;
                dec.imm_ext    = sext16(imm);
                case (rt)
                    RT_BGEZ: dec.alu_control = ALU_BGEZ;
                    RT_BLTZ: dec.alu_control = ALU_BLTZ;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Single-entry decode pipeline register between fetch and the ALU.
// Handshake: a transfer happens on an edge where valid && ready are both 1;
// a producer holds valid (and its data) until that edge, ready may depend
// on the consumer side only. Here in_ready = !out_valid || out_ready, so a
// drain and a new accept on the same edge replace the entry without a bubble.
// flush wins over accept and hold and empties the stage.
module alu_decode_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        flush,
    output logic [4:0]  alu_control,
    output logic [4:0]  as,
    output logic [31:0] imm_ext,
    output logic        use_imm,
    output logic [4:0]  dest,
    output logic        reg_write,
    output logic        is_branch,
    output logic        br_on_zero,
    output logic        illegal,
    output logic [7:0]  illegal_cnt
);

    decoded_t   dec_next;
    decoded_t   dec_q;
    logic       valid_q;
    logic [7:0] cnt_q;
    logic       accept;

    alu_decode_table u_table (
        .instr (instr),
        .dec   (dec_next)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Pipeline entry: flush empties, accept loads, drain without refill empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            dec_q   <= dec_next;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Saturating count of accepted illegal encodings
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'h00;
        end else if (accept && dec_next.illegal && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'h01;
        end
    end

    assign out_valid   = valid_q;
    assign illegal_cnt = cnt_q;
    assign alu_control = dec_q.alu_control;
    assign as          = dec_q.as;
    assign imm_ext     = dec_q.imm_ext;
    assign use_imm     = dec_q.use_imm;
    assign dest        = dec_q.dest;
    assign reg_write   = dec_q.reg_write;
    assign is_branch   = dec_q.is_branch;
    assign br_on_zero  = dec_q.br_on_zero;
    assign illegal     = dec_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode table vectors streamed
// back-to-back, then stall, flush, counter saturation and async reset.
module tb_alu_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  alu;
        logic [4:0]  as_v;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  dest;
        logic        rw;
        logic        br;
        logic        boz;
        logic        ill;
    } vec_t;

    localparam int NVEC = 19;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [4:0]  alu_control;
    logic [4:0]  as;
    logic [31:0] imm_ext;
    logic        use_imm;
    logic [4:0]  dest;
    logic        reg_write;
    logic        is_branch;
    logic        br_on_zero;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    logic [51:0] obs;
    logic [51:0] exp_q[$];
    logic [51:0] exp_b;
    logic [51:0] bundle_a;
    logic [51:0] bundle_b;
    vec_t        vecs[NVEC];
    int          n_checks;
    int          n_fail;
    logic [7:0]  exp_cnt;

    alu_decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .flush       (flush),
        .alu_control (alu_control),
        .as          (as),
        .imm_ext     (imm_ext),
        .use_imm     (use_imm),
        .dest        (dest),
        .reg_write   (reg_write),
        .is_branch   (is_branch),
        .br_on_zero  (br_on_zero),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    assign obs = {alu_control, as, imm_ext, use_imm, dest, reg_write,
                  is_branch, br_on_zero, illegal};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [51:0] pack(input vec_t v);
        return {v.alu, v.as_v, v.imm, v.use_imm, v.dest, v.rw, v.br, v.boz, v.ill};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic v, input logic r, input logic f);
        instr     = i;
        in_valid  = v;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 8'h00;

        //            instr         alu       as     imm            ui    dest   rw    br    boz   ill
        vecs[0]  = '{32'h00221821, 5'b00010, 5'd0,  32'h00000000, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h000521C3, 5'b01010, 5'd7,  32'h00000000, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'h3C011234, 5'b01001, 5'd16, 32'h00001234, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h2002FFFF, 5'b00010, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h04210004, 5'b11011, 5'd0,  32'h00000004, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{32'h1022FFFE, 5'b11000, 5'd0,  32'hFFFFFFFE, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{32'h3443F0F0, 5'b00001, 5'd0,  32'h0000F0F0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'hAC25FFF8, 5'b00010, 5'd0,  32'hFFFFFFF8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32'h8C260010, 5'b00010, 5'd0,  32'h00000010, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'hFC000000, 5'b00000, 5'd0,  32'h00000000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h00000001, 5'b00000, 5'd0,  32'h00000000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{32'h0420FFFF, 5'b11111, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{32'h04220000, 5'b00000, 5'd0,  32'h00000000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{32'h00A63827, 5'b01100, 5'd0,  32'h00000000, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'h28E8FF80, 5'b01000, 5'd0,  32'hFFFFFF80, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{32'h31098000, 5'b00000, 5'd0,  32'h00008000, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{32'h1C600003, 5'b11001, 5'd0,  32'h00000003, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{32'h00854804, 5'b01110, 5'd0,  32'h00000000, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{32'h00021080, 5'b01001, 5'd2,  32'h00000000, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0};

        bundle_a = pack(vecs[0]);
        bundle_b = pack(vecs[2]);

        // Reset state
        rst_n = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #12;
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_in_ready", {63'b0, in_ready}, 64'd1);
        check("reset_cnt", {56'b0, illegal_cnt}, 64'd0);
        check("reset_bundle", {12'b0, obs}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one accept per cycle, continuous drain
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].instr, 1'b1, 1'b1, 1'b0);
            exp_q.push_back(pack(vecs[i]));
            if (vecs[i].ill && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
            tick();
            exp_b = exp_q.pop_front();
            check($sformatf("vec%0d_valid", i), {63'b0, out_valid}, 64'd1);
            check($sformatf("vec%0d_bundle", i), {12'b0, obs}, {12'b0, exp_b});
        end
        check("table_cnt", {56'b0, illegal_cnt}, {56'b0, exp_cnt});

        // Stall: entry A held for 3 cycles while B waits
        drive(vecs[0].instr, 1'b1, 1'b1, 1'b0);
        tick();
        check("stall_load_a", {12'b0, obs}, {12'b0, bundle_a});
        drive(vecs[2].instr, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall%0d_in_ready", c), {63'b0, in_ready}, 64'd0);
            check($sformatf("stall%0d_valid", c), {63'b0, out_valid}, 64'd1);
            check($sformatf("stall%0d_hold", c), {12'b0, obs}, {12'b0, bundle_a});
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {63'b0, in_ready}, 64'd1);
        tick();
        check("no_bubble_valid", {63'b0, out_valid}, 64'd1);
        check("no_bubble_b", {12'b0, obs}, {12'b0, bundle_b});
        drive(32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        check("drain_empty", {63'b0, out_valid}, 64'd0);

        // Flush with a same-cycle illegal request: nothing accepted or counted
        drive(vecs[0].instr, 1'b1, 1'b1, 1'b0);
        tick();
        check("pre_flush_valid", {63'b0, out_valid}, 64'd1);
        drive(32'hFC000000, 1'b1, 1'b0, 1'b1);
        tick();
        check("flush_valid", {63'b0, out_valid}, 64'd0);
        check("flush_cnt", {56'b0, illegal_cnt}, {56'b0, exp_cnt});

        // Counter saturation over 257 illegal accepts
        drive(32'hFC000000, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 257; k++) begin
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'h01;
            tick();
            check($sformatf("ill%0d_flag", k), {63'b0, illegal}, 64'd1);
            check($sformatf("ill%0d_cnt", k), {56'b0, illegal_cnt}, {56'b0, exp_cnt});
        end
        check("cnt_saturated", {56'b0, illegal_cnt}, 64'hFF);

        // Asynchronous reset mid-cycle while holding an entry
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        check("pre_reset_valid", {63'b0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_valid", {63'b0, out_valid}, 64'd0);
        check("async_cnt", {56'b0, illegal_cnt}, 64'd0);
        check("async_bundle", {12'b0, obs}, 64'd0);
        check("async_in_ready", {63'b0, in_ready}, 64'd1);
        drive(vecs[0].instr, 1'b1, 1'b1, 1'b0);
        tick();
        check("in_reset_no_accept", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("first_accept_valid", {63'b0, out_valid}, 64'd1);
        check("first_accept_bundle", {12'b0, obs}, {12'b0, bundle_a});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
